// File: rtl/pipelined_memory.sv
// Single-port synchronous memory with a valid/ready request port, a configurable
// read pipeline and a clear sequencer that fills every word with INIT_VALUE after reset.
module pipelined_memory #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 13,
    parameter int                    DEPTH        = 8192,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_busy
);

    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        clr_cnt_q, clr_cnt_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];

    logic                    in_range;
    logic [IDX_W-1:0]        mem_idx;
    logic                    accept;
    logic                    rd_accept;
    logic [DATA_WIDTH-1:0]   rd_value;

    // Handshake outputs depend only on state and reset, never on req_valid.
    always_comb begin
        req_ready = !rst && (state_q == ST_READY);
        init_busy = rst || (state_q == ST_CLEAR);
        rsp_valid = !rst && pipe_valid_q[READ_LATENCY-1];
        rsp_rdata = pipe_data_q[READ_LATENCY-1];
    end

    always_comb begin
        in_range  = ({1'b0, req_addr} < DEPTH_LIM);
        mem_idx   = req_addr[IDX_W-1:0];
        accept    = req_valid && req_ready;
        rd_accept = accept && !req_write;
        rd_value  = in_range ? mem[mem_idx] : '0;
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = INIT_VALUE;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (accept && req_write && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = mem_idx;
                    mem_wdata = req_wdata;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (rst) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            mem_we    = 1'b0;
        end
    end

    // The last stage is the response register: its data only moves when a response lands.
    always_comb begin
        pipe_valid_d[0] = rd_accept;
        pipe_data_d[0]  = rd_value;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
        if (!pipe_valid_d[READ_LATENCY-1]) begin
            pipe_data_d[READ_LATENCY-1] = pipe_data_q[READ_LATENCY-1];
        end

        if (rst) begin
            pipe_valid_d = '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        clr_cnt_q    <= clr_cnt_d;
        pipe_valid_q <= pipe_valid_d;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed self-checking bench for pipelined_memory: clear, write/read, streaming,
// out-of-range, mid-flight reset and ignored-during-clear requests.
module tb_pipelined_memory;

    localparam int         DW    = 8;
    localparam int         AW    = 11;
    localparam int         DEPTH = 1010;
    localparam int         LAT   = 3;
    localparam logic [7:0] INIT  = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] vals [10] = '{8'd5, 8'd130, 8'd126, 8'd54, 8'd27,
                              8'd100, 8'd3, 8'd12, 8'd110, 8'd15};

    pipelined_memory #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .READ_LATENCY(LAT),
        .INIT_VALUE  (INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Counts busy cycles until READY; the caller must drop req_valid right after.
    task automatic waitClear(input string tag);
        int n = 0;
        int pulses = 0;
        while (init_busy === 1'b1 && n < 5000) begin
            if (rsp_valid !== 1'b0) pulses++;
            n++;
            tick();
        end
        checkOutput({tag, "_len"}, n, DEPTH);
        checkOutput({tag, "_ready"}, req_ready, 1);
        checkOutput({tag, "_pulses"}, pulses, 0);
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic readCheck(input logic [AW-1:0] a, input logic [DW-1:0] want, input string tag);
        applyStimulus(1'b1, 1'b0, a, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int j = 0; j < LAT - 1; j++) begin
            checkOutput({tag, "_early"}, rsp_valid, 0);
            tick();
        end
        checkOutput({tag, "_vld"}, rsp_valid, 1);
        checkOutput({tag, "_data"}, rsp_rdata, want);
        tick();
        checkOutput({tag, "_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        checkOutput("rst_busy", init_busy, 1);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_rspv", rsp_valid, 0);
        checkOutput("rst_rdata", rsp_rdata, 0);

        // Write request held through the whole clear must be ignored.
        applyStimulus(1'b1, 1'b1, 11'd5, 8'h3C);
        rst = 1'b0;
        waitClear("clr1");
        applyStimulus(1'b0, 1'b0, '0, '0);
        readCheck(11'd5, INIT, "ignored");
        readCheck(11'd0, INIT, "clr_w0");
        readCheck(11'd500, INIT, "clr_w500");
        readCheck(11'(DEPTH - 1), INIT, "clr_wlast");

        applyStimulus(1'b1, 1'b1, 11'd1001, 8'd130);
        tick();
        readCheck(11'd1001, 8'd130, "wr_rd");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 11'(1000 + i), vals[i]);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        for (int t = 0; t < 10 + LAT; t++) begin
            if (t < 10) applyStimulus(1'b1, 1'b0, 11'(1000 + t), '0);
            else        applyStimulus(1'b0, 1'b0, '0, '0);
            tick();
            if (t >= LAT - 1 && t - (LAT - 1) < 10) begin
                checkOutput("stream_vld", rsp_valid, 1);
                checkOutput("stream_data", rsp_rdata, vals[t - (LAT - 1)]);
            end else begin
                checkOutput("stream_idle", rsp_valid, 0);
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        checkOutput("hold_vld", rsp_valid, 0);
        checkOutput("hold_data", rsp_rdata, 8'd15);

        writeWord(11'(DEPTH), 8'hFF);
        readCheck(11'(DEPTH), 8'h00, "oor_rd");
        readCheck(11'd2047, 8'h00, "oor_top");
        readCheck(11'(DEPTH - 1), 8'd15, "oor_keep");

        applyStimulus(1'b1, 1'b0, 11'd1002, '0);
        tick();
        checkOutput("mid_v0", rsp_valid, 0);
        applyStimulus(1'b1, 1'b0, 11'd1003, '0);
        tick();
        checkOutput("mid_v1", rsp_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rspv", rsp_valid, 0);
        checkOutput("mid_busy", init_busy, 1);
        checkOutput("mid_ready", req_ready, 0);
        checkOutput("mid_rdata", rsp_rdata, 0);
        waitClear("clr2");
        readCheck(11'd1002, INIT, "post_rst");
        readCheck(11'd0, INIT, "post_w0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
